// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mem_arbiter_pkg
//  Purpose : Shared types for the two-port memory arbiter. Holds the owner
//            encoding used by the arbiter state register and a helper that
//            names the competing port.
//  Ports   : (package, no ports)
//  Rev     : 1.0  initial release
// ============================================================================
package mem_arbiter_pkg;

  // Which port currently owns the memory.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  // The port that competes with the given owner. NONE maps to P0 so that an
  // unowned bus resolves contention in favour of the processor.
  function automatic owner_e other_port(input owner_e own);
    other_port = (own == OWN_P0) ? OWN_P1 : OWN_P0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module  : mem_arbiter_if
//  Purpose : One requester port of the memory arbiter.
//  Ports   : req/we/addr/wdata  requester -> arbiter (held until gnt seen)
//            gnt                arbiter -> requester, combinational accept
//            rvalid/rdata       arbiter -> requester, read response
//  Modports: master (requester side), slave (arbiter side)
//  Rev     : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : mem_arbiter
//  Purpose : Shares one synchronous-read memory between port 0 (processor)
//            and port 1 (loader/debug). One access per cycle; the owner may
//            keep the memory for at most MAX_HOLD consecutive cycles while
//            the other port is waiting.
//  Ports   : clk        system clock, rising edge
//            reset      asynchronous active-high reset
//            p0, p1     requester ports (mem_arbiter_if.slave)
//            mem_addr   address to memory
//            mem_wdata  write data to memory
//            mem_write  memory write strobe
//            mem_rdata  memory read data, valid the cycle after the address
//  Rev     : 1.0  initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  p0,
  mem_arbiter_if.slave  p1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata
);

  localparam int                   c_hold_w   = $clog2(MAX_HOLD + 1);
  localparam logic [c_hold_w-1:0]  c_hold_max = c_hold_w'(MAX_HOLD);
  localparam logic [c_hold_w-1:0]  c_hold_one = c_hold_w'(1);

  owner_e              r_owner;
  owner_e              w_owner_nxt;
  owner_e              w_winner;
  logic [c_hold_w-1:0] r_hold_cnt;
  logic [c_hold_w-1:0] w_hold_nxt;
  logic                r_p0_rvalid;
  logic                r_p1_rvalid;

  // Winner selection. Held in reset so nothing reaches memory while reset
  // is high, even with requests pending.
  always_comb begin
    w_winner = OWN_NONE;
    if (!reset) begin
      case ({p1.req, p0.req})
        2'b01:   w_winner = OWN_P0;
        2'b10:   w_winner = OWN_P1;
        2'b11: begin
          if (r_owner == OWN_NONE)
            w_winner = OWN_P0;
          else if (r_hold_cnt < c_hold_max)
            w_winner = r_owner;
          else
            w_winner = other_port(r_owner);
        end
        default: w_winner = OWN_NONE;
      endcase
    end
  end

  // Next owner / hold count. The count keeps running during uncontended
  // ownership but only matters once both ports request.
  always_comb begin
    w_owner_nxt = w_winner;
    w_hold_nxt  = '0;
    if (w_winner == OWN_NONE)
      w_hold_nxt = '0;
    else if (w_winner == r_owner)
      w_hold_nxt = (r_hold_cnt >= c_hold_max) ? c_hold_max : r_hold_cnt + c_hold_one;
    else
      w_hold_nxt = c_hold_one;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner    <= OWN_NONE;
      r_hold_cnt <= '0;
    end else begin
      r_owner    <= w_owner_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  // Memory request mux.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    case (w_winner)
      OWN_P0: begin
        mem_addr  = p0.addr;
        mem_wdata = p0.wdata;
        mem_write = p0.we;
      end
      OWN_P1: begin
        mem_addr  = p1.addr;
        mem_wdata = p1.wdata;
        mem_write = p1.we;
      end
      default: begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_write = 1'b0;
      end
    endcase
  end

  assign p0.gnt = (w_winner == OWN_P0);
  assign p1.gnt = (w_winner == OWN_P1);

  // Read response tracks the memory's one-cycle read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
    end else begin
      r_p0_rvalid <= p0.gnt & ~p0.we;
      r_p1_rvalid <= p1.gnt & ~p1.we;
    end
  end

  assign p0.rvalid = r_p0_rvalid;
  assign p1.rvalid = r_p1_rvalid;
  assign p0.rdata  = r_p0_rvalid ? mem_rdata : '0;
  assign p1.rdata  = r_p1_rvalid ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mem_arbiter
//  Purpose : Self-checking bench for mem_arbiter: directed scenarios with
//            literal expectations, then randomized traffic compared every
//            cycle against a behavioural model.
//  Ports   : (none)
//  Rev     : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;
  localparam int AW       = 8;
  localparam int DW       = 8;
  localparam int MAX_HOLD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_write;
  logic [DW-1:0] mem_rdata;

  mem_arbiter_if #(.AW(AW), .DW(DW)) p0_if ();
  mem_arbiter_if #(.AW(AW), .DW(DW)) p1_if ();

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .p0        (p0_if),
    .p1        (p1_if),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory unit: unwritten locations read as addr ^ 0x5A.
  logic [DW-1:0] mem_array [256];
  logic [255:0]  mem_valid = '0;
  always @(posedge clk) begin
    mem_rdata <= mem_valid[mem_addr] ? mem_array[mem_addr] : (mem_addr ^ 8'h5A);
    if (mem_write) begin
      mem_array[mem_addr] <= mem_wdata;
      mem_valid[mem_addr] <= 1'b1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_mem [256];
  int         m_owner  = 0;   // 0 none, 1 port0, 2 port1
  int         m_streak = 0;   // consecutive grants to m_owner
  bit         m_rv0 = 0, m_rv1 = 0;
  logic [7:0] m_rd0 = '0, m_rd1 = '0;
  int         wait0 = 0, wait1 = 0;
  bit         last_gnt0 = 0, last_gnt1 = 0;

  initial begin : compare
    int w;
    logic [7:0] ea, ed;
    bit ew;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'(i) ^ 8'h5A;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_rv0 = 0;
        m_rv1 = 0;
        w = 0;
      end else if (!p0_if.req && !p1_if.req) w = 0;
      else if (p0_if.req && !p1_if.req) w = 1;
      else if (!p0_if.req && p1_if.req) w = 2;
      else if (m_owner == 0) w = 1;
      else if (m_streak < MAX_HOLD) w = m_owner;
      else w = 3 - m_owner;

      ea = (w == 1) ? p0_if.addr  : (w == 2) ? p1_if.addr  : 8'h00;
      ed = (w == 1) ? p0_if.wdata : (w == 2) ? p1_if.wdata : 8'h00;
      ew = (w == 1) ? p0_if.we    : (w == 2) ? p1_if.we    : 1'b0;

      check("gnt0", p0_if.gnt, (w == 1));
      check("gnt1", p1_if.gnt, (w == 2));
      check("mem_addr", mem_addr, ea);
      check("mem_wdata", mem_wdata, ed);
      check("mem_write", mem_write, ew);
      check("rvalid0", p0_if.rvalid, m_rv0);
      check("rvalid1", p1_if.rvalid, m_rv1);
      check("rdata0", p0_if.rdata, m_rv0 ? m_rd0 : 8'h00);
      check("rdata1", p1_if.rdata, m_rv1 ? m_rd1 : 8'h00);

      // Starvation bound measured on the DUT's own grants.
      wait0 = (!reset && p0_if.req && !p0_if.gnt) ? wait0 + 1 : 0;
      wait1 = (!reset && p1_if.req && !p1_if.gnt) ? wait1 + 1 : 0;
      if (wait0 > 0) check("wait0_bound", (wait0 <= MAX_HOLD), 1);
      if (wait1 > 0) check("wait1_bound", (wait1 <= MAX_HOLD), 1);
      last_gnt0 = p0_if.gnt;
      last_gnt1 = p1_if.gnt;

      // Advance model across the coming rising edge.
      m_rv0 = (w == 1) && !p0_if.we;
      m_rv1 = (w == 2) && !p1_if.we;
      if (w == 1) m_rd0 = m_mem[p0_if.addr];
      if (w == 2) m_rd1 = m_mem[p1_if.addr];
      if (w != 0 && ew) m_mem[ea] = ed;
      if (w == 0) begin
        m_owner  = 0;
        m_streak = 0;
      end else if (w == m_owner) begin
        m_streak = (m_streak < MAX_HOLD) ? m_streak + 1 : MAX_HOLD;
      end else begin
        m_owner  = w;
        m_streak = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(input int port, input bit req, input bit we,
                     input logic [7:0] a, input logic [7:0] d);
    if (port == 0) begin
      p0_if.req = req; p0_if.we = we; p0_if.addr = a; p0_if.wdata = d;
    end else begin
      p1_if.req = req; p1_if.we = we; p1_if.addr = a; p1_if.wdata = d;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    logic [15:0] pat;
    int n1;
    bit p0_won;

    // Reset with both ports requesting.
    reset = 1'b1;
    drv(0, 1, 0, 8'h10, 8'h00);
    drv(1, 1, 0, 8'h30, 8'h00);
    @(negedge clk);
    check("t1_gnt0_rst", p0_if.gnt, 0);
    check("t1_gnt1_rst", p1_if.gnt, 0);
    check("t1_wr_rst", mem_write, 0);
    check("t1_rv0_rst", p0_if.rvalid, 0);
    check("t1_rv1_rst", p1_if.rvalid, 0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("t1_gnt0_first", p0_if.gnt, 1);
    check("t1_gnt1_first", p1_if.gnt, 0);

    // Port 0 back-to-back reads of 0x10, 0x11.
    next_cycle();
    drv(0, 1, 0, 8'h11, 8'h00);
    @(negedge clk);
    check("t2_gnt0", p0_if.gnt, 1);
    check("t2_rv0_a", p0_if.rvalid, 1);
    check("t2_rd0_a", p0_if.rdata, 8'h4A);
    next_cycle();
    drv(0, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    check("t2_rv0_b", p0_if.rvalid, 1);
    check("t2_rd0_b", p0_if.rdata, 8'h4B);
    next_cycle();
    drv(1, 0, 0, 8'h00, 8'h00);
    @(negedge clk);

    // Continuous contention: P0x4, P1x4, ...
    next_cycle();
    drv(0, 1, 0, 8'h01, 8'h00);
    drv(1, 1, 0, 8'h02, 8'h00);
    pat = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pat = {pat[14:0], p0_if.gnt};
      next_cycle();
    end
    check("t3_pattern", pat, 16'hF0F0);

    // P1 writes 0xA5 to 0x20, then P0 reads it back.
    drv(0, 0, 0, 8'h00, 8'h00);
    drv(1, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    next_cycle();
    drv(1, 1, 1, 8'h20, 8'hA5);
    @(negedge clk);
    check("t4_gnt1", p1_if.gnt, 1);
    check("t4_write", mem_write, 1);
    check("t4_waddr", mem_addr, 8'h20);
    next_cycle();
    drv(1, 0, 0, 8'h00, 8'h00);
    drv(0, 1, 0, 8'h20, 8'h00);
    @(negedge clk);
    check("t4_gnt0", p0_if.gnt, 1);
    check("t4_nowrite", mem_write, 0);
    next_cycle();
    drv(0, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    check("t4_rv0", p0_if.rvalid, 1);
    check("t4_rd0", p0_if.rdata, 8'hA5);

    // P1 owns, P0 joins: P1 keeps up to the hold limit.
    next_cycle();
    drv(1, 1, 0, 8'h40, 8'h00);
    @(negedge clk);
    check("t5_gnt1_alone", p1_if.gnt, 1);
    n1 = 1;
    p0_won = 0;
    next_cycle();
    drv(0, 1, 0, 8'h41, 8'h00);
    drv(1, 1, 0, 8'h42, 8'h00);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (p0_if.gnt) begin
        p0_won = 1;
        break;
      end
      if (p1_if.gnt) n1++;
      next_cycle();
    end
    check("t5_p0_granted", p0_won, 1);
    check("t5_p1_grants", n1, 4);
    next_cycle();
    drv(0, 0, 0, 8'h00, 8'h00);
    drv(1, 0, 0, 8'h00, 8'h00);
    @(negedge clk);

    // Reset right after a granted read.
    next_cycle();
    drv(1, 1, 0, 8'h50, 8'h00);
    @(negedge clk);
    check("t6_gnt1", p1_if.gnt, 1);
    next_cycle();
    reset = 1'b1;
    drv(1, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    check("t6_rv1_dropped", p1_if.rvalid, 0);
    next_cycle();
    reset = 1'b0;
    drv(0, 1, 0, 8'h51, 8'h00);
    drv(1, 1, 0, 8'h52, 8'h00);
    @(negedge clk);
    check("t6_gnt0_after", p0_if.gnt, 1);
    check("t6_rv1_after", p1_if.rvalid, 0);

    // Randomized traffic; requesters hold until granted.
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      reset = ($urandom_range(0, 299) == 0);
      if (!(p0_if.req && !last_gnt0))
        drv(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
            8'($urandom_range(0, 15)), 8'($urandom));
      if (!(p1_if.req && !last_gnt1))
        drv(1, ($urandom_range(0, 2) != 0), ($urandom_range(0, 1) == 0),
            8'($urandom_range(0, 15)), 8'($urandom));
    end
    next_cycle();
    reset = 1'b0;
    drv(0, 0, 0, 8'h00, 8'h00);
    drv(1, 0, 0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
